key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_conditioner_if.sv | 32 +++
 rtl/debounce_ch.sv | 143 ++++++++++++++
 rtl/key_conditioner.sv | 92 +++++++++
 tb/tb_key_conditioner.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared channel state encoding, default timing constants and counter helper
package key_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } ch_state_e;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYC = 32'd500000;
    localparam int unsigned DEF_REPEAT_DELAY = 32'd25000000;
    localparam int unsigned DEF_REPEAT_RATE  = 32'd5000000;
    localparam logic [3:0]  DEF_REPEAT_MASK  = 4'b1100;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw switch inputs and conditioned key outputs
interface key_conditioner_if;

    logic [3:0] sw_raw;
    logic [7:0] bin_raw;
    logic [3:0] sw_level;
    logic [3:0] sw_press;
    logic [3:0] sw_release;
    logic [7:0] bin_val;
    logic       bin_chg;

    modport master (
        output sw_raw,
        output bin_raw,
        input  sw_level,
        input  sw_press,
        input  sw_release,
        input  bin_val,
        input  bin_chg
    );

    modport slave (
        input  sw_raw,
        input  bin_raw,
        output sw_level,
        output sw_press,
        output sw_release,
        output bin_val,
        output bin_chg
    );

endinterface

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one toggle channel: synchronizer, debounce FSM, edge pulses
// Auto-repeat logic exists only under KEY_CONDITIONER_AUTO_REPEAT_EN
module debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN    = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    logic        sync_a;
    logic        sync_b;
    ch_state_e   state;
    ch_state_e   state_n;
    logic [31:0] cnt;
    logic [31:0] cnt_n;
    logic [31:0] cnt_inc;
    logic        press_n;
    logic        release_n;
    logic        rpt_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOW;
            cnt           <= 32'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    assign cnt_inc = sat_inc(cnt);

    // cnt holds how many consecutive cycles the opposite level has been seen
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        unique case (state)
            LOW: begin
                if (sync_b) begin
                    state_n = ARM_HI;
                    cnt_n   = 32'd1;
                end
            end
            ARM_HI: begin
                if (!sync_b) begin
                    state_n = LOW;
                    cnt_n   = 32'd0;
                end else if (cnt_inc >= DEBOUNCE_CYC) begin
                    state_n = HIGH;
                    cnt_n   = 32'd0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HIGH: begin
                if (!sync_b) begin
                    state_n = ARM_LO;
                    cnt_n   = 32'd1;
                end else begin
                    press_n = rpt_fire;
                end
            end
            ARM_LO: begin
                if (sync_b) begin
                    state_n = HIGH;
                    cnt_n   = 32'd0;
                end else if (cnt_inc >= DEBOUNCE_CYC) begin
                    state_n   = LOW;
                    cnt_n     = 32'd0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = 32'd0;
            end
        endcase
    end

    assign level = (state == HIGH) || (state == ARM_LO);

`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    if (REPEAT_EN) begin : g_rpt
        logic [31:0] rpt_cnt;
        logic [31:0] rpt_inc;
        logic [31:0] rpt_lim;
        logic        rpt_phase;

        // phase 0 waits out the initial delay, phase 1 runs at the repeat rate
        assign rpt_inc  = sat_inc(rpt_cnt);
        assign rpt_lim  = rpt_phase ? REPEAT_RATE : REPEAT_DELAY;
        assign rpt_fire = (state == HIGH) && sync_b && (rpt_inc >= rpt_lim);

        always_ff @(posedge clk) begin
            if (!rst_n || (state != HIGH) || !sync_b) begin
                rpt_cnt   <= 32'd0;
                rpt_phase <= 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt   <= 32'd0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt <= rpt_inc;
            end
        end
    end else begin : g_no_rpt
        assign rpt_fire = 1'b0;
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - four debounced toggle channels plus a group-debounced 8-bit switch word
// Optional auto-repeat on masked channels: KEY_CONDITIONER_AUTO_REPEAT_EN
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter logic [3:0]  REPEAT_MASK  = DEF_REPEAT_MASK
) (
    input  logic             clk,
    input  logic             rst_n,
    key_conditioner_if.slave kif
);

    logic [3:0] sw_level;
    logic [3:0] sw_press;
    logic [3:0] sw_release;

    for (genvar i = 0; i < 4; i++) begin : g_ch
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (kif.sw_raw[i]),
            .level         (sw_level[i]),
            .press_pulse   (sw_press[i]),
            .release_pulse (sw_release[i])
        );
`else
        debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (kif.sw_raw[i]),
            .level         (sw_level[i]),
            .press_pulse   (sw_press[i]),
            .release_pulse (sw_release[i])
        );
`endif
    end

    assign kif.sw_level   = sw_level;
    assign kif.sw_press   = sw_press;
    assign kif.sw_release = sw_release;

    logic [7:0]  bin_sync_a;
    logic [7:0]  bin_sync_b;
    logic [7:0]  bin_cand;
    logic [7:0]  bin_val;
    logic [31:0] bin_cnt;
    logic [31:0] bin_cnt_inc;
    logic        bin_chg;

    assign bin_cnt_inc = sat_inc(bin_cnt);

    // bin_cand tracks the last synchronized word; any bit change restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sync_a <= 8'd0;
            bin_sync_b <= 8'd0;
            bin_cand   <= 8'd0;
            bin_val    <= 8'd0;
            bin_cnt    <= 32'd0;
            bin_chg    <= 1'b0;
        end else begin
            bin_sync_a <= kif.bin_raw;
            bin_sync_b <= bin_sync_a;
            bin_chg    <= 1'b0;
            if (bin_sync_b != bin_cand) begin
                bin_cand <= bin_sync_b;
                bin_cnt  <= 32'd1;
            end else begin
                bin_cnt <= bin_cnt_inc;
                if ((bin_cand != bin_val) && (bin_cnt_inc >= DEBOUNCE_CYC)) begin
                    bin_val <= bin_cand;
                    bin_chg <= 1'b1;
                end
            end
        end
    end

    assign kif.bin_val = bin_val;
    assign kif.bin_chg = bin_chg;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed and randomized checks of key_conditioner against a run-length model
module tb_key_conditioner;

    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [3:0] MASK = 4'b1100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [3:0] h1, h2, m_level, m_press, m_rel;
    logic [7:0] bh1, bh2, m_bin, b_prev;
    logic       m_chg;
    int         run[4];
    int         hi_age[4];
    int         b_stable;
    int         press_cnt[4];
    int         press_cyc[4];
    int         rel_cyc[4];
    int         chg_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Level flips once the 2-cycle-delayed input has disagreed with it for DB straight cycles
    task automatic model_step(input logic rst, input logic [3:0] raw, input logic [7:0] braw);
        logic [3:0] s;
        logic [7:0] bs;
        logic [3:0] mask_v;
        bit         was_high;
        mask_v  = MASK;
        m_press = 4'd0;
        m_rel   = 4'd0;
        m_chg   = 1'b0;
        if (!rst) begin
            h1 = 4'd0; h2 = 4'd0; bh1 = 8'd0; bh2 = 8'd0;
            m_level = 4'd0; m_bin = 8'd0; b_prev = 8'd0; b_stable = 0;
            for (int ch = 0; ch < 4; ch++) begin
                run[ch]    = 0;
                hi_age[ch] = 0;
            end
            return;
        end
        s  = h2;  h2  = h1;  h1  = raw;
        bs = bh2; bh2 = bh1; bh1 = braw;
        for (int ch = 0; ch < 4; ch++) begin
            was_high = m_level[ch] && (run[ch] == 0);
            if (s[ch] != m_level[ch]) begin
                run[ch]++;
                if (run[ch] >= DB) begin
                    m_level[ch] = s[ch];
                    run[ch]     = 0;
                    if (s[ch]) m_press[ch] = 1'b1;
                    else       m_rel[ch]   = 1'b1;
                end
            end else begin
                run[ch] = 0;
            end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
            if (mask_v[ch] && m_level[ch] && (run[ch] == 0)) begin
                if (!was_high) begin
                    hi_age[ch] = 0;
                end else begin
                    hi_age[ch]++;
                    if (hi_age[ch] == RD || (hi_age[ch] > RD && ((hi_age[ch] - RD) % RR) == 0))
                        m_press[ch] = 1'b1;
                end
            end
`else
            if (mask_v[ch] && was_high) hi_age[ch] = 0;
`endif
        end
        if (bs == b_prev) b_stable++;
        else              b_stable = 1;
        b_prev = bs;
        if (bs != m_bin && b_stable >= DB) begin
            m_bin = bs;
            m_chg = 1'b1;
        end
    endtask

    task automatic tick();
        logic       r;
        logic [3:0] sr;
        logic [7:0] br;
        r  = rst_n;
        sr = kif.sw_raw;
        br = kif.bin_raw;
        @(posedge clk);
        #1;
        cyc++;
        model_step(r, sr, br);
        check("sw_level",   32'(kif.sw_level),   32'(m_level));
        check("sw_press",   32'(kif.sw_press),   32'(m_press));
        check("sw_release", 32'(kif.sw_release), 32'(m_rel));
        check("bin_val",    32'(kif.bin_val),    32'(m_bin));
        check("bin_chg",    32'(kif.bin_chg),    32'(m_chg));
        for (int ch = 0; ch < 4; ch++) begin
            if (kif.sw_press[ch] === 1'b1) begin
                press_cnt[ch]++;
                press_cyc[ch] = cyc;
            end
            if (kif.sw_release[ch] === 1'b1) rel_cyc[ch] = cyc;
        end
        if (kif.bin_chg === 1'b1) chg_cnt++;
    endtask

    initial begin
        int c, p, p0, p3, c0, idx;
        for (int ch = 0; ch < 4; ch++) begin
            press_cnt[ch] = 0; press_cyc[ch] = 0; rel_cyc[ch] = 0;
        end
        chg_cnt = 0;
        kif.sw_raw  = 4'd0;
        kif.bin_raw = 8'd0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({kif.sw_level, kif.sw_press, kif.sw_release, kif.bin_val, kif.bin_chg}), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        c = cyc;
        kif.sw_raw[1] = 1'b1;
        repeat (8) tick();
        check("clean_latency", press_cyc[1] - c, 6);
        check("clean_count", press_cnt[1], 1);
        check("clean_level", 32'(kif.sw_level), 32'h2);
        check("clean_others", press_cnt[0] + press_cnt[2] + press_cnt[3], 0);

        p = press_cnt[2];
        kif.sw_raw[2] = 1'b1; tick();
        kif.sw_raw[2] = 1'b0; tick();
        kif.sw_raw[2] = 1'b1; tick();
        kif.sw_raw[2] = 1'b0; tick();
        kif.sw_raw[2] = 1'b1;
        c = cyc;
        repeat (9) tick();
        check("bounce_count", press_cnt[2] - p, 1);
        check("bounce_latency", press_cyc[2] - c, 6);

        kif.sw_raw[0] = 1'b1;
        repeat (8) tick();
        c = cyc;
        kif.sw_raw[0] = 1'b0;
        kif.sw_raw[3] = 1'b1;
        repeat (8) tick();
        check("simul_release_latency", rel_cyc[0] - c, 6);
        check("simul_press_latency", press_cyc[3] - c, 6);

        c0 = chg_cnt;
        kif.bin_raw = 8'hA5;
        repeat (8) tick();
        check("bin_load_val", 32'(kif.bin_val), 32'hA5);
        check("bin_load_chg", chg_cnt - c0, 1);
        kif.bin_raw = 8'hB5; tick(); tick();
        kif.bin_raw = 8'hA5;
        repeat (8) tick();
        check("bin_glitch_chg", chg_cnt - c0, 1);
        check("bin_glitch_val", 32'(kif.bin_val), 32'hA5);

        kif.sw_raw  = 4'd0;
        kif.bin_raw = 8'd0;
        repeat (8) tick();
        p = press_cnt[1];
        kif.sw_raw[1] = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_outputs", 32'({kif.sw_level, kif.sw_press, kif.sw_release, kif.bin_val, kif.bin_chg}), 32'd0);
        check("rst_mid_no_pulse", press_cnt[1] - p, 0);
        rst_n = 1'b1;
        c = cyc;
        repeat (8) tick();
        check("rst_mid_latency", press_cyc[1] - c, 6);
        check("rst_mid_count", press_cnt[1] - p, 1);

        kif.sw_raw = 4'd0;
        repeat (8) tick();
        c  = cyc;
        p0 = press_cnt[0];
        p3 = press_cnt[3];
        kif.sw_raw[3] = 1'b1;
        kif.sw_raw[0] = 1'b1;
        repeat (30) tick();
        check("rpt_unmasked_count", press_cnt[0] - p0, 1);
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        check("rpt_masked_count", press_cnt[3] - p3, 6);
        check("rpt_masked_last", press_cyc[3] - c, 28);
`else
        check("rpt_masked_count", press_cnt[3] - p3, 1);
        check("rpt_masked_last", press_cyc[3] - c, 6);
`endif

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 3);
                kif.sw_raw[idx] = ~kif.sw_raw[idx];
            end
            if ($urandom_range(0, 11) == 0) begin
                idx = $urandom_range(0, 7);
                kif.bin_raw[idx] = ~kif.bin_raw[idx];
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
